modred_sched: RTL

Round-robin scheduler that shares one `ModRed` reduction unit between up to four requesters (field multipliers of the point-arithmetic and signature datapaths). It accepts a 512-bit product from the granted requester and drives the `ModRed` start/busy handshake. It then applies the final conditional subtraction of p, so every returned result is fully reduced (< p). Each grant ends with a one-cycle completion pulse to that requester.

---
 rtl/modred_sched_pkg.sv | 34 +++
 rtl/ModRed.sv | 63 ++++++
 rtl/modred_sched.sv | 127 ++++++++++++
 3 files changed

// File: rtl/modred_sched_pkg.sv
// Shared definitions for the ModRed scheduler: secp256k1 modulus, state encodings
// and the single-pass fold used by the reduction unit.
package modred_sched_pkg;

    localparam logic [255:0] P256K1 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    localparam int unsigned FOLD_CYC = 8;

    typedef enum logic [2:0] {
        SchIdle,
        SchLaunch,
        SchRun,
        SchCorr,
        SchDone
    } sch_state_t;

    typedef enum logic [1:0] {
        MrInit,
        MrSetup,
        MrFold,
        MrHold
    } mr_state_t;

    // 2^256 == 2^32 + 977 (mod P), so hi*2^256 + lo folds to lo + hi*(2^32 + 977).
    function automatic logic [511:0] fold256k1(input logic [511:0] x);
        logic [511:0] hi;
        logic [511:0] lo;
        hi = {256'd0, x[511:256]};
        lo = {256'd0, x[255:0]};
        return lo + (hi << 32) + hi * 512'd977;
    endfunction

endpackage

// File: rtl/ModRed.sv
// Iterative secp256k1 folding reducer: start/busy handshake, one fold per 8-cycle pass.
// Result b is < 2^256 but not necessarily < P; the caller finishes the reduction.
module ModRed
    import modred_sched_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [511:0] a,
    output logic         busy,
    output logic [255:0] b
);

    mr_state_t    state, state_nxt;
    logic [511:0] acc;
    logic [511:0] folded;
    logic [2:0]   tmr;

    assign folded = fold256k1(acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MrInit;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MrInit:  if (start) state_nxt = MrSetup;
            MrSetup: state_nxt = MrFold;
            MrFold:  if (tmr == 3'd0 && folded[511:256] == 256'd0) state_nxt = MrHold;
            MrHold:  state_nxt = MrHold;
            default: state_nxt = MrInit;
        endcase
        // Dropping start always returns the unit to its ready state.
        if (!start) state_nxt = MrInit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            tmr <= '0;
        end else begin
            case (state)
                MrInit:  if (start) acc <= a;
                MrSetup: tmr <= 3'(FOLD_CYC - 1);
                MrFold: begin
                    if (tmr == 3'd0) begin
                        acc <= folded;
                        tmr <= 3'(FOLD_CYC - 1);
                    end else begin
                        tmr <= tmr - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == MrSetup) || (state == MrFold);
    assign b    = acc[255:0];

endmodule

// File: rtl/modred_sched.sv
// Round-robin scheduler sharing one ModRed between NREQ requesters, with final
// conditional subtraction of P so every result is fully reduced.
//
// state     | meaning
// SchIdle   | ModRed held ready; arbitrate and register winner's operand
// SchLaunch | mr_start high; wait for ModRed to report busy
// SchRun    | wait for ModRed busy to fall; capture its result
// SchCorr   | subtract P once if result >= P; load res
// SchDone   | done/gnt pulse for the served requester; update last
module modred_sched
    import modred_sched_pkg::*;
#(
    parameter int           NREQ = 2,
    parameter logic [255:0] P    = P256K1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*512-1:0] op,
    output logic [NREQ-1:0]     gnt,
    output logic [255:0]        res,
    output logic                done,
    output logic                busy
);

    sch_state_t   state, state_nxt;
    logic [511:0] opreg;
    logic [511:0] op_sel;
    logic [255:0] rreg;
    logic [255:0] rcorr;
    logic [1:0]   cur;
    logic [1:0]   last;
    logic [1:0]   pick;
    logic         mr_start;
    logic         mr_busy;
    logic [255:0] mr_b;

    // Search order last+1 .. NREQ-1, then 0 .. last; later assignments win.
    function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] r, input logic [1:0] lst);
        logic [1:0] w;
        w = lst;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (r[i] && i <= int'(lst)) w = 2'(i);
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (r[i] && i > int'(lst)) w = 2'(i);
        end
        return w;
    endfunction

    assign pick = rr_pick(req, last);

    always_comb begin
        op_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == 2'(i)) op_sel = op[512*i +: 512];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SchIdle;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SchIdle:   if (|req) state_nxt = SchLaunch;
            SchLaunch: if (mr_busy) state_nxt = SchRun;
            SchRun:    if (!mr_busy) state_nxt = SchCorr;
            SchCorr:   state_nxt = SchDone;
            SchDone:   state_nxt = SchIdle;
            default:   state_nxt = SchIdle;
        endcase
    end

    // ModRed output is below 2^256 < 2P, so one subtraction always suffices.
    assign rcorr = (rreg >= P) ? (rreg - P) : rreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opreg <= '0;
            rreg  <= '0;
            res   <= '0;
            cur   <= '0;
            last  <= 2'(NREQ - 1);
        end else begin
            case (state)
                SchIdle: begin
                    if (|req) begin
                        opreg <= op_sel;
                        cur   <= pick;
                    end
                end
                SchRun:  if (!mr_busy) rreg <= mr_b;
                SchCorr: begin
                    rreg <= rcorr;
                    res  <= rcorr;
                end
                SchDone: last <= cur;
                default: ;
            endcase
        end
    end

    // Decoded from the state register so an async reset clears them at once.
    assign mr_start = (state == SchLaunch) || (state == SchRun) || (state == SchCorr);
    assign busy     = (state != SchIdle);
    assign done     = (state == SchDone);

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = done && (cur == 2'(i));
        end
    end

    ModRed u_modred (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mr_start),
        .a     (opreg),
        .busy  (mr_busy),
        .b     (mr_b)
    );

endmodule
